sram_rr_arbiter: RTL



---
 rtl/sram_rr_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Round-robin arbiter that serialises read/write requests from N_CH
//   requesters onto one asynchronous SRAM port. Each granted access holds
//   the SRAM strobes for WAIT_STATES+1 cycles. It is followed by one
//   turnaround cycle (DONE) that pulses the requester's completion bit.
//
// Ports
//   Clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   writeRequest   per-channel write request (level)
//   readRequest    per-channel read request (level)
//   addr_in        packed channel addresses, channel c at [c*ADDR_W +: ADDR_W]
//   data_in        packed channel write data, same packing
//   sram_rdata     read data returned from the SRAM data tristate
//   addressToSRAM  SRAM address, held from grant until the next grant
//   sram_wdata     SRAM write data, held from grant until the next grant
//   sram_data_oe   tristate drive enable, high only while writing
//   SRAM_CE/WE/RE  active-low chip, write and output enables
//   DataToCPUs     data of the most recent completed read
//   requestDone    one-cycle completion pulse, one bit per channel
//   grant_id       channel of the current or most recent transaction
//   busy           high whenever a transaction is in flight (not IDLE)
module sram_rr_arbiter #(
  parameter int N_CH        = 5,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 1,
  localparam int GW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          writeRequest,
  input  logic [N_CH-1:0]          readRequest,
  input  logic [N_CH*ADDR_W-1:0]   addr_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic [DATA_W-1:0]        sram_rdata,
  output logic [ADDR_W-1:0]        addressToSRAM,
  output logic [DATA_W-1:0]        sram_wdata,
  output logic                     sram_data_oe,
  output logic                     SRAM_CE,
  output logic                     SRAM_WE,
  output logic                     SRAM_RE,
  output logic [DATA_W-1:0]        DataToCPUs,
  output logic [N_CH-1:0]          requestDone,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            is_write;
  logic [GW-1:0]   last_grant;

  logic [N_CH-1:0] pending;
  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  int              idx;

  function automatic logic [N_CH-1:0] onehot(input logic [GW-1:0] g);
    logic [N_CH-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  assign pending = writeRequest | readRequest;

  // Round-robin search: first pending channel after last_grant, wrapping.
  // Offsets run 1..N_CH so the last granted channel is considered last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = GW'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      is_write      <= 1'b0;
      last_grant    <= GW'(N_CH - 1);
      addressToSRAM <= '0;
      sram_wdata    <= '0;
      sram_data_oe  <= 1'b0;
      SRAM_CE       <= 1'b1;
      SRAM_WE       <= 1'b1;
      SRAM_RE       <= 1'b1;
      DataToCPUs    <= '0;
      requestDone   <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            // Write wins when both request bits are set on the channel.
            grant_id      <= pick;
            addressToSRAM <= addr_in[int'(pick)*ADDR_W +: ADDR_W];
            sram_wdata    <= data_in[int'(pick)*DATA_W +: DATA_W];
            is_write      <= writeRequest[pick];
            wait_cnt      <= WS_LOAD;
            busy          <= 1'b1;
            SRAM_CE       <= 1'b0;
            if (writeRequest[pick]) begin
              SRAM_WE      <= 1'b0;
              sram_data_oe <= 1'b1;
            end else begin
              SRAM_RE      <= 1'b0;
            end
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            // Last access cycle: sample read data before releasing strobes.
            if (!is_write) DataToCPUs <= sram_rdata;
            SRAM_CE      <= 1'b1;
            SRAM_WE      <= 1'b1;
            SRAM_RE      <= 1'b1;
            sram_data_oe <= 1'b0;
            requestDone  <= onehot(grant_id);
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          // Bus turnaround cycle; the pointer moves past this channel.
          requestDone <= '0;
          last_grant  <= grant_id;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
